// File: rtl/face_classifier_mul_arb.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters.
// The operand stage drives the multiplier and the response stage captures its product.
module face_classifier_mul_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         mul_din0,
  output logic [DATA_WIDTH-1:0]         mul_din1,
  input  logic [DATA_WIDTH-1:0]         mul_dout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_p,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          busy
);

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
  logic [ID_WIDTH-1:0]   s1_id_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_p_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

  logic                  s2_free, s1_free;
  logic                  grant_found, grant_en;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  assign s2_free = !rsp_valid_q || rsp_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; first valid requester wins.
  always_comb begin
    int j;
    grant_found = 1'b0;
    grant_id    = '0;
    j           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == j && !grant_found && req_valid[i]) begin
          grant_found = 1'b1;
          grant_id    = ID_WIDTH'(i);
        end
      end
    end
  end

  assign grant_en  = s1_free && !ap_rst && grant_found;
  assign req_ready = grant_en ? (NUM_REQ'(1) << grant_id) : '0;
  assign ptr_d     = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      if (s1_free) begin
        if (grant_en) begin
          s1_valid_q <= 1'b1;
          s1_a_q     <= sel_a;
          s1_b_q     <= sel_b;
          s1_id_q    <= grant_id;
          ptr_q      <= ptr_d;
        end else begin
          s1_valid_q <= 1'b0;
        end
      end
      // s2_free implies s1_free, so S1 and S2 shift together.
      if (s2_free) begin
        rsp_valid_q <= s1_valid_q;
        rsp_p_q     <= mul_dout;
        rsp_id_q    <= s1_id_q;
      end
    end
  end

  assign mul_din0  = s1_a_q;
  assign mul_din1  = s1_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_face_classifier_mul_arb.sv
// Bench for face_classifier_mul_arb: vector table, scoreboard of grants vs responses,
// and hand sequences for round robin, backpressure, idle skipping and mid-flight reset.
module tb_face_classifier_mul_arb;
  localparam int N  = 4;
  localparam int DW = 12;
  localparam int IW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a, req_b;
  logic [DW-1:0]     mul_din0, mul_din1, mul_dout;
  logic              rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_p;
  logic [IW-1:0]     rsp_id;
  logic              busy;

  face_classifier_mul_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  // Shared multiplier stand-in.
  logic signed [2*DW-1:0] mul_full;
  assign mul_full = $signed(mul_din0) * $signed(mul_din1);
  assign mul_dout = mul_full[DW-1:0];

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] p;
  } sb_t;

  typedef struct {
    int            id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_p;
  } vec_t;

  sb_t sb_q[$];
  int  grant_log[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] f;
    f = $signed(a) * $signed(b);
    return f[DW-1:0];
  endfunction

  // Scoreboard: push on each grant handshake, pop on each response handshake.
  always @(negedge ap_clk) begin
    sb_t e;
    if (!ap_rst) begin
      check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = IW'(i);
          e.p  = exp_prod(req_a[i*DW +: DW], req_b[i*DW +: DW]);
          sb_q.push_back(e);
          grant_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %0d p 0x%0h, expected no response", rsp_id, rsp_p);
        end else begin
          e = sb_q.pop_front();
          check("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          check("sb_rsp_p", 32'(rsp_p), 32'(e.p));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i]        = v;
    req_a[i*DW +: DW]   = a;
    req_b[i*DW +: DW]   = b;
  endtask

  task automatic rand_ops(input int i);
    req_a[i*DW +: DW] = DW'($urandom);
    req_b[i*DW +: DW] = DW'($urandom);
  endtask

  // Run n cycles; requesters that transferred get fresh operands.
  task automatic run_cycles(input int n);
    logic [N-1:0] g;
    for (int c = 0; c < n; c++) begin
      @(negedge ap_clk);
      g = req_valid & req_ready;
      @(posedge ap_clk); #1;
      for (int i = 0; i < N; i++) if (g[i]) rand_ops(i);
    end
  endtask

  task automatic do_reset();
    ap_rst    = 1'b1;
    req_valid = '0;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic drain();
    int k;
    k = 0;
    rsp_ready = 1'b1;
    while (busy && k < 50) begin
      @(posedge ap_clk); #1;
      k++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_log(input string name, input int exp[]);
    check({name, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      check(name, (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(exp[k]));
  endtask

  vec_t vecs[4];
  logic [DW-1:0] hold_p;
  logic [IW-1:0] hold_id;

  initial begin
    vecs[0] = '{2, 12'd3,     -12'sd4, 12'hFF4};
    vecs[1] = '{0, 12'd100,   12'd100, 12'h710};
    vecs[2] = '{1, 12'h800,   12'hFFF, 12'h800};
    vecs[3] = '{3, -12'sd7,   12'd5,   12'hFDD};

    ap_rst    = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_din0", 32'(mul_din0), 32'd0);
    check("rst_mul_din1", 32'(mul_din1), 32'd0);
    check("rst_rsp_p", 32'(rsp_p), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    ap_rst    = 1'b0;

    // Single-request vectors: grant in the request cycle, response two edges later.
    for (int v = 0; v < 4; v++) begin
      set_req(vecs[v].id, 1'b1, vecs[v].a, vecs[v].b);
      @(negedge ap_clk);
      check("vec_req_ready", 32'(req_ready), 32'(1) << vecs[v].id);
      @(posedge ap_clk); #1;
      req_valid[vecs[v].id] = 1'b0;
      @(posedge ap_clk);
      @(negedge ap_clk);
      check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      check("vec_rsp_p", 32'(rsp_p), 32'(vecs[v].exp_p));
      check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      @(posedge ap_clk); #1;
    end
    drain();

    // Round robin with all requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      rand_ops(i);
    end
    grant_log.delete();
    run_cycles(8);
    req_valid = '0;
    check_log("rr_grant", '{0, 1, 2, 3, 0, 1, 2, 3});
    drain();

    // Backpressure with both stages full.
    req_valid = '1;
    run_cycles(3);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      if (c == 0) begin
        hold_p  = rsp_p;
        hold_id = rsp_id;
      end else begin
        check("bp_rsp_p_stable", 32'(rsp_p), 32'(hold_p));
        check("bp_rsp_id_stable", 32'(rsp_id), 32'(hold_id));
      end
      @(posedge ap_clk); #1;
    end
    rsp_ready = 1'b1;
    run_cycles(5);
    req_valid = '0;
    drain();

    // Idle requesters are skipped: move ptr to 2 via requester 1, then 1 and 3 compete.
    do_reset();
    set_req(1, 1'b1, 12'd9, 12'd9);
    @(negedge ap_clk);
    check("skip_setup_ready", 32'(req_ready), 32'b0010);
    @(posedge ap_clk); #1;
    req_valid = '0;
    grant_log.delete();
    set_req(1, 1'b1, 12'd11, -12'sd3);
    set_req(3, 1'b1, -12'sd50, 12'd41);
    run_cycles(4);
    req_valid = '0;
    check_log("skip_grant", '{3, 1, 3, 1});
    drain();

    // Reset while both stages hold entries.
    req_valid = '1;
    run_cycles(3);
    rsp_ready = 1'b0;
    run_cycles(2);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_pre_busy", 32'(busy), 32'd1);
    @(posedge ap_clk); #1;
    ap_rst    = 1'b0;
    req_valid = '0;
    sb_q.delete();
    @(negedge ap_clk);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready_idle", 32'(req_ready), 32'd0);
    @(posedge ap_clk); #1;
    rsp_ready = 1'b1;
    set_req(2, 1'b1, 12'd7, 12'd6);
    set_req(3, 1'b1, 12'd5, 12'd4);
    @(negedge ap_clk);
    check("post_rst_first_grant", 32'(req_ready), 32'b0100);
    @(posedge ap_clk); #1;
    run_cycles(1);
    req_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end
endmodule
